// File: rtl/clock_pkg.sv
// Shared types and constants for the BCD clock blocks (stopwatch, countdown timer).
// MM:SS values are packed as {min_tens, min_ones, sec_tens, sec_ones}.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } sw_state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t  SEC_TENS_MAX = 4'd5;
  localparam bcd_digit_t  DIGIT_MAX    = 4'd9;
  localparam logic [15:0] MMSS_ZERO    = 16'h0000;

  // True when every digit is in range for an MM:SS value.
  function automatic logic is_legal_mmss(input logic [15:0] v);
    return (v[15:12] <= DIGIT_MAX) && (v[11:8] <= DIGIT_MAX) &&
           (v[7:4] <= SEC_TENS_MAX) && (v[3:0] <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_inc.sv
// One BCD digit of a ripple incrementer: rolls to zero past limit and carries out.
module bcd_digit_inc
  import clock_pkg::*;
(
  input  bcd_digit_t digit,
  input  bcd_digit_t limit,
  input  logic       cin,
  output bcd_digit_t next,
  output logic       cout
);

  logic at_limit;

  assign at_limit = (digit == limit);
  assign cout     = cin & at_limit;

  always_comb begin
    next = digit;
    if (cin) begin
      next = at_limit ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_stopwatch.sv
// BCD MM:SS count-up stopwatch with start/stop/clear, lap capture, stop target
// and saturate-or-wrap overflow. The FSM state is exported for observation.
module bcd_stopwatch
  import clock_pkg::*;
#(
  parameter logic [15:0] MAX_TIME = 16'h9959,
  parameter bit          WRAP     = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        lap,
  input  logic [15:0] target,
  output logic [15:0] min_sec,
  output logic [15:0] lap_time,
  output logic        running,
  output logic        done,
  output logic        overflow,
  output sw_state_e   state
);

  sw_state_e   state_n;
  logic [15:0] count_q;
  logic [15:0] lap_q;
  logic        done_q;
  logic        ovf_q;
  logic [15:0] inc_val;
  logic [15:0] next_val;
  logic [4:0]  carry;
  logic        tick_en;
  logic        at_max;
  logic        sat_evt;
  logic        wrap_evt;
  logic        hit_evt;
  logic        ovf_n;

  assign carry[0] = 1'b1;

  bcd_digit_inc u_sec_ones (
    .digit(count_q[3:0]),   .limit(DIGIT_MAX),    .cin(carry[0]),
    .next (inc_val[3:0]),   .cout (carry[1])
  );
  bcd_digit_inc u_sec_tens (
    .digit(count_q[7:4]),   .limit(SEC_TENS_MAX), .cin(carry[1]),
    .next (inc_val[7:4]),   .cout (carry[2])
  );
  bcd_digit_inc u_min_ones (
    .digit(count_q[11:8]),  .limit(DIGIT_MAX),    .cin(carry[2]),
    .next (inc_val[11:8]),  .cout (carry[3])
  );
  bcd_digit_inc u_min_tens (
    .digit(count_q[15:12]), .limit(DIGIT_MAX),    .cin(carry[3]),
    .next (inc_val[15:12]), .cout (carry[4])
  );

  // The chain's final carry only fires at 99:59, which is never below MAX_TIME.
  assign at_max   = (count_q == MAX_TIME) || carry[4];
  assign tick_en  = (state == RUN) && tick;
  assign sat_evt  = tick_en && at_max && !WRAP;
  assign wrap_evt = tick_en && at_max && WRAP;
  assign next_val = at_max ? (WRAP ? MMSS_ZERO : count_q) : inc_val;
  assign hit_evt  = tick_en && !at_max && (target != MMSS_ZERO) &&
                    is_legal_mmss(target) && (inc_val == target);
  assign ovf_n    = WRAP ? wrap_evt : (ovf_q | sat_evt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Clear beats stop beats start; a stop racing a target hit still lands in DONE.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start && !stop) state_n = RUN;
      RUN: begin
        if (sat_evt || hit_evt) state_n = DONE;
        else if (stop)          state_n = PAUSE;
      end
      PAUSE:   if (start && !stop) state_n = RUN;
      DONE:    state_n = DONE;
      default: state_n = IDLE;
    endcase
    if (clear) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= MMSS_ZERO;
      lap_q   <= MMSS_ZERO;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (clear) begin
      count_q <= MMSS_ZERO;
      lap_q   <= MMSS_ZERO;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (tick_en) count_q <= next_val;
      if (lap && (state != IDLE)) lap_q <= count_q;
      done_q <= done_q | hit_evt;
      ovf_q  <= ovf_n;
    end
  end

  assign min_sec  = count_q;
  assign lap_time = lap_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign running  = (state == RUN);

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch: a saturating instance (u_sat) and a wrapping
// instance (u_wrap) share one stimulus; expected values are hand-computed.
module tb_bcd_stopwatch;
  import clock_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [15:0] target = 16'h0000;
  logic [15:0] min_sec_s, lap_time_s, min_sec_w, lap_time_w;
  logic        running_s, done_s, overflow_s, running_w, done_w, overflow_w;
  sw_state_e   state_s, state_w;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  bcd_stopwatch #(.MAX_TIME(16'h9959), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .lap(lap), .target(target), .min_sec(min_sec_s),
    .lap_time(lap_time_s), .running(running_s), .done(done_s),
    .overflow(overflow_s), .state(state_s)
  );

  bcd_stopwatch #(.MAX_TIME(16'h9959), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .lap(lap), .target(target), .min_sec(min_sec_w),
    .lap_time(lap_time_w), .running(running_w), .done(done_w),
    .overflow(overflow_w), .state(state_w)
  );

  // Driver tasks: inputs are set 1 time unit after a posedge, outputs read there too.
  task automatic cycle();
    @(posedge clk);
    #1;
    tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cycle();
    end
  endtask

  task automatic do_clear_start();
    clear = 1'b1;
    cycle();
    start = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) cycle();
    vectors++;
    if ({min_sec_s, lap_time_s, running_s, done_s, overflow_s} !== 35'd0 || state_s !== IDLE) begin
      miscompares++;
      $display("FAIL reset: min_sec=%h lap=%h run=%b done=%b ovf=%b state=%0d expected all 0/IDLE",
               min_sec_s, lap_time_s, running_s, done_s, overflow_s, state_s);
    end
    #2 rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_count();
    start = 1'b1;
    cycle();
    do_ticks(75);
    vectors++;
    if (min_sec_s !== 16'h0115 || running_s !== 1'b1 || done_s !== 1'b0 || overflow_s !== 1'b0) begin
      miscompares++;
      $display("FAIL count75: min_sec=%h run=%b done=%b ovf=%b expected 0115/1/0/0",
               min_sec_s, running_s, done_s, overflow_s);
    end
  endtask

  task automatic test_target();
    target = 16'h0010;
    do_clear_start();
    do_ticks(10);
    vectors++;
    if (min_sec_s !== 16'h0010 || done_s !== 1'b1 || running_s !== 1'b0 || state_s !== DONE) begin
      miscompares++;
      $display("FAIL target_hit: min_sec=%h done=%b run=%b state=%0d expected 0010/1/0/DONE",
               min_sec_s, done_s, running_s, state_s);
    end
    do_ticks(3);
    start = 1'b1;
    cycle();
    vectors++;
    if (min_sec_s !== 16'h0010 || state_s !== DONE) begin
      miscompares++;
      $display("FAIL target_hold: min_sec=%h state=%0d expected 0010/DONE", min_sec_s, state_s);
    end
    clear = 1'b1;
    cycle();
    vectors++;
    if (min_sec_s !== 16'h0000 || done_s !== 1'b0 || state_s !== IDLE) begin
      miscompares++;
      $display("FAIL target_clear: min_sec=%h done=%b state=%0d expected 0000/0/IDLE",
               min_sec_s, done_s, state_s);
    end
    target = 16'h0000;
  endtask

  task automatic test_overflow();
    do_clear_start();
    do_ticks(5999);
    vectors++;
    if (min_sec_s !== 16'h9959 || min_sec_w !== 16'h9959) begin
      miscompares++;
      $display("FAIL reach_max: sat=%h wrap=%h expected 9959", min_sec_s, min_sec_w);
    end
    do_ticks(1);
    vectors++;
    if (min_sec_s !== 16'h9959 || overflow_s !== 1'b1 || state_s !== DONE || done_s !== 1'b0) begin
      miscompares++;
      $display("FAIL saturate: min_sec=%h ovf=%b state=%0d done=%b expected 9959/1/DONE/0",
               min_sec_s, overflow_s, state_s, done_s);
    end
    vectors++;
    if (min_sec_w !== 16'h0000 || overflow_w !== 1'b1 || running_w !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap: min_sec=%h ovf=%b run=%b expected 0000/1/1",
               min_sec_w, overflow_w, running_w);
    end
    do_ticks(1);
    vectors++;
    if (overflow_w !== 1'b0 || min_sec_w !== 16'h0001 || overflow_s !== 1'b1 || min_sec_s !== 16'h9959) begin
      miscompares++;
      $display("FAIL ovf_after: wrap_ovf=%b wrap=%h sat_ovf=%b sat=%h expected 0/0001/1/9959",
               overflow_w, min_sec_w, overflow_s, min_sec_s);
    end
  endtask

  task automatic test_pause_lap();
    do_clear_start();
    do_ticks(42);
    stop = 1'b1;
    cycle();
    do_ticks(5);
    vectors++;
    if (min_sec_s !== 16'h0042 || state_s !== PAUSE) begin
      miscompares++;
      $display("FAIL pause_hold: min_sec=%h state=%0d expected 0042/PAUSE", min_sec_s, state_s);
    end
    target = 16'h0010;
    lap = 1'b1;
    cycle();
    vectors++;
    if (lap_time_s !== 16'h0042) begin
      miscompares++;
      $display("FAIL lap_pause: lap_time=%h expected 0042", lap_time_s);
    end
    start = 1'b1;
    tick = 1'b1;
    cycle();
    vectors++;
    if (min_sec_s !== 16'h0042 || state_s !== RUN) begin
      miscompares++;
      $display("FAIL start_tick: min_sec=%h state=%0d expected 0042/RUN", min_sec_s, state_s);
    end
    do_ticks(1);
    vectors++;
    if (min_sec_s !== 16'h0043 || done_s !== 1'b0) begin
      miscompares++;
      $display("FAIL resume_tick: min_sec=%h done=%b expected 0043/0 (target below count)",
               min_sec_s, done_s);
    end
    target = 16'h0000;
  endtask

  task automatic test_simultaneous();
    do_clear_start();
    do_ticks(59);
    lap = 1'b1;
    tick = 1'b1;
    cycle();
    vectors++;
    if (lap_time_s !== 16'h0059 || min_sec_s !== 16'h0100) begin
      miscompares++;
      $display("FAIL lap_tick: lap_time=%h min_sec=%h expected 0059/0100", lap_time_s, min_sec_s);
    end
    stop = 1'b1;
    tick = 1'b1;
    cycle();
    vectors++;
    if (min_sec_s !== 16'h0101 || state_s !== PAUSE) begin
      miscompares++;
      $display("FAIL stop_tick: min_sec=%h state=%0d expected 0101/PAUSE", min_sec_s, state_s);
    end
    start = 1'b1;
    cycle();
    clear = 1'b1;
    tick = 1'b1;
    cycle();
    vectors++;
    if (min_sec_s !== 16'h0000 || lap_time_s !== 16'h0000 || state_s !== IDLE) begin
      miscompares++;
      $display("FAIL clear_tick: min_sec=%h lap=%h state=%0d expected 0000/0000/IDLE",
               min_sec_s, lap_time_s, state_s);
    end
    lap = 1'b1;
    tick = 1'b1;
    cycle();
    vectors++;
    if (lap_time_s !== 16'h0000 || min_sec_s !== 16'h0000) begin
      miscompares++;
      $display("FAIL idle_lap_tick: lap=%h min_sec=%h expected 0000/0000", lap_time_s, min_sec_s);
    end
  endtask

  task automatic test_async_reset();
    do_clear_start();
    do_ticks(333);
    lap = 1'b1;
    cycle();
    vectors++;
    if (min_sec_s !== 16'h0533 || lap_time_s !== 16'h0533) begin
      miscompares++;
      $display("FAIL pre_reset: min_sec=%h lap=%h expected 0533/0533", min_sec_s, lap_time_s);
    end
    tick = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({min_sec_s, lap_time_s, running_s, done_s, overflow_s} !== 35'd0 || state_s !== IDLE) begin
      miscompares++;
      $display("FAIL async_reset: min_sec=%h lap=%h run=%b state=%0d expected 0/0/0/IDLE",
               min_sec_s, lap_time_s, running_s, state_s);
    end
    start = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    vectors++;
    if (min_sec_s !== 16'h0000 || running_s !== 1'b0 || state_s !== IDLE) begin
      miscompares++;
      $display("FAIL reset_held: min_sec=%h run=%b state=%0d expected 0000/0/IDLE",
               min_sec_s, running_s, state_s);
    end
    start = 1'b0;
    #2 rst_n = 1'b1;
    do_ticks(2);
    vectors++;
    if (min_sec_s !== 16'h0000 || state_s !== IDLE) begin
      miscompares++;
      $display("FAIL post_reset: min_sec=%h state=%0d expected 0000/IDLE", min_sec_s, state_s);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_count();
    test_target();
    test_overflow();
    test_pause_lap();
    test_simultaneous();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
